// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, defaults, entry type and FSM encoding for the fetch unit
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] PC_INC_DEFAULT   = 32'd4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int                FIFO_DEPTH_DEFAULT = 2;

  localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0000;

  // Fetch FSM encoding
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Redirect targets are always word aligned.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - instruction-memory, redirect and decode handshake bundle
//   master (fetch unit): drives pc, if_valid, if_inst, if_pc
//   slave  (memory/execute/decode side): drives inst_reg, redirect, redirect_pc, if_ready
interface inst_fetch_unit_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] inst_reg;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;

  modport master (
    output pc, if_valid, if_inst, if_pc,
    input  inst_reg, redirect, redirect_pc, if_ready
  );

  modport slave (
    input  pc, if_valid, if_inst, if_pc,
    output inst_reg, redirect, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry buffer of {pc,inst} pairs with flush and push+pop on full
//   clk, rst_n      : clock, async active-low reset
//   push, wdata     : write entry at tail
//   pop             : drop head entry
//   flush           : empty the buffer (wins over push/pop)
//   rdata, count    : head entry, occupancy
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch PC, instruction capture, fetch buffer and decode handoff
//   clk, rst_n : clock, async active-low reset
//   bus        : inst_fetch_unit_if.master (pc/inst_reg, redirect, decode valid/ready)
//   FETCH_PERF_EN defined: adds fetch_cnt and stall_cnt outputs
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter logic [ADDR_W-1:0] PC_INC     = PC_INC_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  inst_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc_q;
  logic [CW-1:0]     count;
  fetch_entry_t      head;
  fetch_entry_t      wentry;
  logic              has_entry;
  logic              pop;
  logic              push;

  assign has_entry = (count != '0) && (state == ST_RUN);

  // Redirect wins over both pop and push.
  assign pop  = has_entry && bus.if_ready && !bus.redirect;
  assign push = !bus.redirect && ((count < CW'(FIFO_DEPTH)) || pop);

  assign wentry = '{pc: pc_q, inst: bus.inst_reg};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (bus.redirect),
    .rdata (head),
    .count (count)
  );

  // FLUSH covers the cycle after a redirect: the buffer is empty and pc
  // already holds the target, so the word sampled there is the new stream's.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      pc_q  <= RESET_PC;
    end else begin
      state <= bus.redirect ? ST_FLUSH : ST_RUN;
      if (bus.redirect)
        pc_q <= align_pc(bus.redirect_pc);
      else if (push)
        pc_q <= pc_q + PC_INC;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.if_valid = has_entry;
  assign bus.if_inst  = has_entry ? head.inst : NOP_WORD;
  assign bus.if_pc    = has_entry ? head.pc   : '0;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (push && fetch_cnt != 32'hFFFF_FFFF)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (has_entry && !bus.if_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  inst_fetch_unit_if bus();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  inst_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2),
    .PC_INC     (32'd4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Instruction memory contents: word n holds (n+1)*0x11.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  always_comb bus.inst_reg = mem_word(bus.pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc,inst} with a fetch address.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;
  bit          m_has, m_take, m_room;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pc    = 32'h0;
      m_fetch = 32'h0;
      m_stall = 32'h0;
    end else begin
      m_has  = mq.size() > 0;
      m_take = m_has && bus.if_ready;
      if (m_has && !bus.if_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (bus.redirect) begin
        mq.delete();
        m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      end else begin
        m_room = (mq.size() < 2) || m_take;
        if (m_take) void'(mq.pop_front());
        if (m_room) begin
          mq.push_back({m_pc, mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
          if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 1;
        end
      end
    end
  end

  logic [63:0] m_head;
  always @(negedge clk) begin
    m_head = (mq.size() > 0) ? mq[0] : 64'h0;
    chk("m_if_valid", {31'd0, bus.if_valid}, {31'd0, mq.size() > 0});
    chk("m_if_pc",    bus.if_pc,   m_head[63:32]);
    chk("m_if_inst",  bus.if_inst, m_head[31:0]);
    chk("m_pc",       bus.pc,      m_pc);
`ifdef FETCH_PERF_EN
    chk("m_fetch_cnt", fetch_cnt, m_fetch);
    chk("m_stall_cnt", stall_cnt, m_stall);
`endif
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.if_ready    = 1'b1;
    step(2);
    chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_inst",  bus.if_inst, 32'h0);
    chk("rst_ifpc",  bus.if_pc,   32'h0);
    chk("rst_pc",    bus.pc,      32'h0);

    // Reset release, decode always ready
    rst_n = 1'b1;
    step(1);
    chk("a_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("a_pc0",   bus.if_pc,   32'h0);
    chk("a_inst0", bus.if_inst, 32'h11);
    step(1);
    chk("a_pc1",   bus.if_pc,   32'h4);
    chk("a_inst1", bus.if_inst, 32'h22);
    step(1);
    chk("a_pc2",   bus.if_pc,   32'h8);
    chk("a_inst2", bus.if_inst, 32'h33);

    // Async reset between edges, then stall for five cycles
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("ar_inst",  bus.if_inst, 32'h0);
    chk("ar_pc",    bus.pc,      32'h0);
    bus.if_ready = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("b_valid", {31'd0, bus.if_valid}, 32'd1);
    step(5);
    chk("b_pc_hold", bus.pc,      32'h8);
    chk("b_inst",    bus.if_inst, 32'h11);
    chk("b_ifpc",    bus.if_pc,   32'h0);
`ifdef FETCH_PERF_EN
    chk("b_stall", stall_cnt, 32'd5);
    chk("b_fetch", fetch_cnt, 32'd2);
`endif

    // Full buffer drained at one word per cycle
    bus.if_ready = 1'b1;
    step(1);
    chk("c_pc4",  bus.if_pc, 32'h4);
    step(1);
    chk("c_pc8",  bus.if_pc, 32'h8);
    chk("c_i8",   bus.if_inst, 32'h33);
    step(1);
    chk("c_pc12", bus.if_pc, 32'hC);
    step(1);
    chk("c_pc16", bus.if_pc, 32'h10);
    chk("c_i16",  bus.if_inst, 32'h55);

    // Redirect to unaligned target with full buffer
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    step(1);
    bus.redirect = 1'b0;
    chk("d_valid0", {31'd0, bus.if_valid}, 32'd0);
    chk("d_pc",     bus.pc, 32'h100);
    step(1);
    chk("d_valid1", {31'd0, bus.if_valid}, 32'd1);
    chk("d_ifpc",   bus.if_pc,   32'h100);
    chk("d_inst",   bus.if_inst, 32'h451);

    // Back-to-back redirects: the last one wins
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    step(1);
    bus.redirect_pc = 32'h302;
    step(1);
    bus.redirect = 1'b0;
    chk("e_valid0", {31'd0, bus.if_valid}, 32'd0);
    chk("e_pc",     bus.pc, 32'h300);
    step(1);
    chk("e_ifpc",   bus.if_pc,   32'h300);
    chk("e_inst",   bus.if_inst, 32'hCD1);

    // Stalled full buffer discarded by redirect, then wrap of pc
    bus.if_ready = 1'b0;
    step(3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    bus.if_ready    = 1'b1;
    step(1);
    bus.redirect = 1'b0;
    chk("f_valid0", {31'd0, bus.if_valid}, 32'd0);
    chk("f_pc",     bus.pc, 32'hFFFF_FFF8);
    step(1);
    chk("f_ifpc0", bus.if_pc, 32'hFFFF_FFF8);
    step(1);
    chk("f_ifpc1", bus.if_pc, 32'hFFFF_FFFC);
    step(1);
    chk("f_ifpc2", bus.if_pc, 32'h0);
    chk("f_inst2", bus.if_inst, 32'h11);

    // Mid-stream async reset
    rst_n = 1'b0;
    #1;
    chk("g_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("g_ifpc",  bus.if_pc,   32'h0);
    chk("g_inst",  bus.if_inst, 32'h0);
    chk("g_pc",    bus.pc,      32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("g_first_ifpc", bus.if_pc,   32'h0);
    chk("g_first_inst", bus.if_inst, 32'h11);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
